// File: rtl/counter_wrap_logger_if.sv
// rtl/counter_wrap_logger_if.sv - wrap-event FIFO drain port (FWFT head plus valid/ready)
interface counter_wrap_logger_if #(
    parameter int TS_W = 16
) ();
    logic            evt_valid;
    logic            evt_ready;
    logic            evt_dir;
    logic [TS_W-1:0] evt_stamp;

    modport master (
        output evt_valid,
        output evt_dir,
        output evt_stamp,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_dir,
        input  evt_stamp,
        output evt_ready
    );
endinterface

// File: rtl/counter_wrap_logger.sv
// rtl/counter_wrap_logger.sv - wrap-extended count, timestamped wrap-event FIFO, drop and protocol-error tracking
module counter_wrap_logger #(
    parameter int EXT_W = 4,
    parameter int TS_W  = 16,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      up_down,
    input  logic [3:0]                cnt,
    input  logic                      overflow,
    output logic [EXT_W+3:0]          ext_cnt,
    counter_wrap_logger_if.master     evt,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic [7:0]                drop_cnt,
    output logic                      proto_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [TS_W-1:0]  ts_q;
    logic [EXT_W-1:0] wrap_hi_q, wrap_hi_d;
    logic [EXT_W+3:0] ext_cnt_q;
    logic             dir_mem_q   [DEPTH];
    logic [TS_W-1:0]  stamp_mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q, level_d;
    logic [7:0]       drop_cnt_q;
    logic             proto_err_q;

    logic push_req, pop, full, push_ok, drop;

    always_comb begin
        push_req  = overflow && en;
        pop       = (level_q != '0) && evt.evt_ready;
        full      = (level_q == LVL_W'(DEPTH));
        // a full FIFO still accepts a push when the head leaves in the same cycle
        push_ok   = push_req && (!full || pop);
        drop      = push_req && full && !pop;
        wrap_hi_d = wrap_hi_q;
        if (push_req) begin
            wrap_hi_d = up_down ? wrap_hi_q + EXT_W'(1) : wrap_hi_q - EXT_W'(1);
        end
        level_d   = level_q + LVL_W'(push_ok) - LVL_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts_q        <= '0;
            wrap_hi_q   <= '0;
            ext_cnt_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            drop_cnt_q  <= '0;
            proto_err_q <= 1'b0;
        end else begin
            ts_q      <= ts_q + TS_W'(1);
            wrap_hi_q <= wrap_hi_d;
            ext_cnt_q <= {wrap_hi_d, cnt};
            level_q   <= level_d;
            if (push_ok) begin
                dir_mem_q[wr_ptr_q]   <= up_down;
                stamp_mem_q[wr_ptr_q] <= ts_q;
                wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (drop && drop_cnt_q != 8'hFF) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end
            if (overflow && !en) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    // head fields read as zero while empty so stale entries never leak out
    assign evt.evt_valid = (level_q != '0);
    assign evt.evt_dir   = (level_q != '0) ? dir_mem_q[rd_ptr_q]   : 1'b0;
    assign evt.evt_stamp = (level_q != '0) ? stamp_mem_q[rd_ptr_q] : '0;
    assign ext_cnt       = ext_cnt_q;
    assign fifo_level    = level_q;
    assign drop_cnt      = drop_cnt_q;
    assign proto_err     = proto_err_q;
endmodule

// File: tb/tb_counter_wrap_logger.sv
// tb/tb_counter_wrap_logger.sv - vector table plus event scoreboard for counter_wrap_logger
module tb_counter_wrap_logger;
    localparam int EXT_W = 4;
    localparam int TS_W  = 16;
    localparam int DEPTH = 4;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       up_down;
        logic [3:0] cnt;
        logic       overflow;
        logic       ready;
        logic [7:0] e_ext;
        int         e_lvl;
        int         e_drop;
        logic       e_err;
    } vec_t;

    typedef struct packed {
        logic            dir;
        logic [TS_W-1:0] stamp;
    } evt_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             up_down = 1'b0;
    logic [3:0]       cnt = 4'd0;
    logic             overflow = 1'b0;
    logic [EXT_W+3:0] ext_cnt;
    logic [2:0]       fifo_level;
    logic [7:0]       drop_cnt;
    logic             proto_err;

    counter_wrap_logger_if #(.TS_W(TS_W)) evt_bus ();

    counter_wrap_logger #(.EXT_W(EXT_W), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .up_down    (up_down),
        .cnt        (cnt),
        .overflow   (overflow),
        .ext_cnt    (ext_cnt),
        .evt        (evt_bus),
        .fifo_level (fifo_level),
        .drop_cnt   (drop_cnt),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    int        checks = 0;
    int        errors = 0;
    int        step_no = 0;
    logic [15:0] ts_m = 16'd0;
    evt_t      sb_q[$];
    vec_t      tbl[$];

    function automatic vec_t mk(logic r, logic e, logic u, logic [3:0] c, logic o, logic y,
                                logic [7:0] ext, int lvl, int drp, logic err);
        vec_t v;
        v.rst_n = r; v.en = e; v.up_down = u; v.cnt = c; v.overflow = o; v.ready = y;
        v.e_ext = ext; v.e_lvl = lvl; v.e_drop = drp; v.e_err = err;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL step %0d %s: got %0d expected %0d", step_no, name, act, exp);
        end
    endtask

    task automatic step(input vec_t v);
        int   sz;
        logic pop;
        evt_t e;
        rst_n    = v.rst_n;
        en       = v.en;
        up_down  = v.up_down;
        cnt      = v.cnt;
        overflow = v.overflow;
        evt_bus.evt_ready = v.ready;
        sz  = sb_q.size();
        pop = (sz > 0) && v.ready;
        if (!v.rst_n) begin
            sb_q.delete();
        end else begin
            if (pop) void'(sb_q.pop_front());
            if (v.en && v.overflow && (sz < DEPTH || pop)) begin
                e.dir   = v.up_down;
                e.stamp = ts_m;
                sb_q.push_back(e);
            end
        end
        @(posedge clk);
        ts_m = v.rst_n ? ts_m + 16'd1 : 16'd0;
        #1;
        chk("ext_cnt", int'(ext_cnt), int'(v.e_ext));
        chk("fifo_level", int'(fifo_level), v.e_lvl);
        chk("drop_cnt", int'(drop_cnt), v.e_drop);
        chk("proto_err", int'(proto_err), int'(v.e_err));
        if (sb_q.size() == 0) begin
            chk("evt_valid", int'(evt_bus.evt_valid), 0);
            chk("evt_dir", int'(evt_bus.evt_dir), 0);
            chk("evt_stamp", int'(evt_bus.evt_stamp), 0);
        end else begin
            chk("evt_valid", int'(evt_bus.evt_valid), 1);
            chk("evt_dir", int'(evt_bus.evt_dir), int'(sb_q[0].dir));
            chk("evt_stamp", int'(evt_bus.evt_stamp), int'(sb_q[0].stamp));
        end
        step_no++;
    endtask

    initial begin
        vec_t v;
        int   n;
        evt_bus.evt_ready = 1'b0;

        // reset held two cycles with overflow asserted
        tbl.push_back(mk(0, 1, 1, 15, 1, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 15, 1, 0, 8'h00, 0, 0, 0));
        for (int i = 0; i < 20; i++) tbl.push_back(mk(1, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0));
        // up wrap at ts=20, then counter shows 0
        tbl.push_back(mk(1, 1, 1, 15, 1, 0, 8'h1F, 1, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 8'h10, 1, 0, 0));
        // down wrap from reset
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 8'hF0, 1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 15, 0, 0, 8'hFF, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 15, 0, 1, 8'hFF, 0, 0, 0));
        // six overflows into a 4-deep FIFO with no reader
        tbl.push_back(mk(1, 1, 1, 15, 1, 0, 8'h0F, 1, 0, 0));
        tbl.push_back(mk(1, 1, 1, 15, 1, 0, 8'h1F, 2, 0, 0));
        tbl.push_back(mk(1, 1, 1, 15, 1, 0, 8'h2F, 3, 0, 0));
        tbl.push_back(mk(1, 1, 1, 15, 1, 0, 8'h3F, 4, 0, 0));
        tbl.push_back(mk(1, 1, 1, 15, 1, 0, 8'h4F, 4, 1, 0));
        tbl.push_back(mk(1, 1, 1, 15, 1, 0, 8'h5F, 4, 2, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 1, 8'h50, 3, 2, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 1, 8'h50, 2, 2, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 1, 8'h50, 1, 2, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 1, 8'h50, 0, 2, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 1, 8'h50, 0, 2, 0));
        // refill, then push and pop together while full
        tbl.push_back(mk(1, 1, 1, 15, 1, 0, 8'h6F, 1, 2, 0));
        tbl.push_back(mk(1, 1, 1, 15, 1, 0, 8'h7F, 2, 2, 0));
        tbl.push_back(mk(1, 1, 1, 15, 1, 0, 8'h8F, 3, 2, 0));
        tbl.push_back(mk(1, 1, 1, 15, 1, 0, 8'h9F, 4, 2, 0));
        tbl.push_back(mk(1, 1, 1, 15, 1, 1, 8'hAF, 4, 2, 0));
        // overflow without enable, then reset with three entries queued
        tbl.push_back(mk(1, 0, 1, 3, 1, 0, 8'hA3, 4, 2, 1));
        tbl.push_back(mk(1, 0, 1, 3, 0, 0, 8'hA3, 4, 2, 1));
        tbl.push_back(mk(1, 0, 1, 3, 0, 1, 8'hA3, 3, 2, 1));
        tbl.push_back(mk(0, 1, 1, 15, 1, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0));

        foreach (tbl[i]) step(tbl[i]);

        // drop counter saturation: 262 overflows with no reader
        for (int i = 0; i < 262; i++) begin
            n = i + 1;
            v = mk(1, 1, 1, 15, 1, 0, {4'(n), 4'hF}, (n < DEPTH) ? n : DEPTH,
                   (n <= DEPTH) ? 0 : ((n - DEPTH > 255) ? 255 : n - DEPTH), 0);
            step(v);
        end
        for (int i = 0; i < 5; i++) begin
            v = mk(1, 0, 1, 0, 0, 1, 8'h60, (3 - i > 0) ? 3 - i : 0, 255, 0);
            step(v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
